// File: rtl/plic_pkg.sv
// plic_pkg: shared gateway state encoding and trigger-mode constants.
package plic_pkg;

    typedef enum logic [1:0] {GW_IDLE, GW_PENDING, GW_CLAIMED} gw_state_t;

    localparam logic GW_MODE_LEVEL = 1'b0;
    localparam logic GW_MODE_EDGE  = 1'b1;

endpackage

// File: rtl/plic_gateway_edge_cnt.sv
// plic_gateway_edge_cnt: rising-edge detector plus saturating up/down count of unforwarded edges.
// PLIC_GATEWAY_EDGE_COUNT_EN selects a full counter; otherwise a 1-bit sticky flag.
module plic_gateway_edge_cnt #(
    parameter int MAX_PENDING_COUNT = 8,
    parameter int CNT_BITS = $clog2(MAX_PENDING_COUNT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                src,
    input  logic                inc_en,
    input  logic                dec,
    input  logic                clr,
    output logic                rise,
    output logic [CNT_BITS-1:0] cnt
);

`ifdef PLIC_GATEWAY_EDGE_COUNT_EN
    localparam int W   = CNT_BITS;
    localparam int MAX = MAX_PENDING_COUNT;
`else
    localparam int W   = 1;
    localparam int MAX = 1;
`endif
    localparam logic [W-1:0] MAX_Q = W'(MAX);

    logic         src_q;
    logic [W-1:0] q;
    logic         inc;

    assign rise = src & ~src_q;
    assign inc  = rise & inc_en;
    assign cnt  = CNT_BITS'(q);

    // Saturated increments are dropped, not queued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= 1'b0;
            q     <= '0;
        end else begin
            src_q <= src;
            if (clr)
                q <= '0;
            else if (inc && !dec && q != MAX_Q)
                q <= q + 1'b1;
            else if (dec && !inc)
                q <= q - 1'b1;
        end
    end

endmodule

// File: rtl/plic_gateway.sv
// plic_gateway: per-source PLIC gateway turning a level/edge request into ip_o with claim/complete handshake.
// Edge-count depth is set by PLIC_GATEWAY_EDGE_COUNT_EN (undefined: single sticky edge flag).
module plic_gateway
    import plic_pkg::*;
#(
    parameter int MAX_PENDING_COUNT = 8,
    parameter int CNT_BITS = $clog2(MAX_PENDING_COUNT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                src_i,
    input  logic                edge_lvl_i,
    input  logic                claim_i,
    input  logic                complete_i,
    output logic                ip_o,
    output logic [CNT_BITS-1:0] cnt_o
);

    gw_state_t     state, state_n;
    logic          rise, req, take, cnt_nz, edge_mode;
    logic [CNT_BITS-1:0] cnt;

    assign edge_mode = (edge_lvl_i == GW_MODE_EDGE);
    assign cnt_nz    = |cnt;
    assign req       = edge_mode ? (rise | cnt_nz) : src_i;
    assign take      = (state == GW_IDLE) & req;
    assign cnt_o     = cnt;

    // An edge that directly triggers IDLE->PENDING is consumed, never stored.
    plic_gateway_edge_cnt #(
        .MAX_PENDING_COUNT(MAX_PENDING_COUNT),
        .CNT_BITS         (CNT_BITS)
    ) u_edge_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .src   (src_i),
        .inc_en(edge_mode & ~take),
        .dec   (take & cnt_nz & ~rise),
        .clr   (~edge_mode),
        .rise  (rise),
        .cnt   (cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= GW_IDLE;
            ip_o  <= 1'b0;
        end else begin
            state <= state_n;
            ip_o  <= (state_n == GW_PENDING);
        end
    end

    // Completion always lands in IDLE so ip_o drops for at least one cycle.
    always_comb begin
        state_n = state;
        case (state)
            GW_IDLE:    if (req) state_n = GW_PENDING;
            GW_PENDING: if (claim_i) state_n = GW_CLAIMED;
            GW_CLAIMED: if (complete_i) state_n = GW_IDLE;
            default:    state_n = GW_IDLE;
        endcase
    end

endmodule

// File: tb/tb_plic_gateway.sv
// tb_plic_gateway: directed stimulus checked against a behavioural gateway model each cycle.
module tb_plic_gateway;

    localparam int MAXP = 8;
    localparam int CW   = $clog2(MAXP + 1);
`ifdef PLIC_GATEWAY_EDGE_COUNT_EN
    localparam int MAXC = MAXP;
`else
    localparam int MAXC = 1;
`endif

    logic clk = 1'b0, rst_ni = 1'b0;
    logic src_i = 1'b0, edge_lvl_i = 1'b0, claim_i = 1'b0, complete_i = 1'b0;
    logic ip_o;
    logic [CW-1:0] cnt_o;

    int checks = 0, failures = 0;
    bit m_ip, m_busy, m_prev;
    int m_cnt;

    always #5 clk = ~clk;

    plic_gateway #(.MAX_PENDING_COUNT(MAXP)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .src_i     (src_i),
        .edge_lvl_i(edge_lvl_i),
        .claim_i   (claim_i),
        .complete_i(complete_i),
        .ip_o      (ip_o),
        .cnt_o     (cnt_o)
    );

    function automatic int sat(input int n);
        return (n < MAXC) ? n : MAXC;
    endfunction

    task automatic chk(input string name, input logic [CW-1:0] act, input int exp);
        checks++;
        if (act !== CW'(exp)) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_ip = 0; m_busy = 0; m_prev = 0; m_cnt = 0;
    endfunction

    // Model: pending flag, in-service flag and an integer queue depth of stored edges.
    function automatic void model_step();
        bit e    = src_i && !m_prev;
        bit idle = !m_ip && !m_busy;
        bit r    = edge_lvl_i ? (e || m_cnt > 0) : src_i;
        if (!edge_lvl_i) m_cnt = 0;
        else if (idle && r) begin if (!e) m_cnt--; end
        else if (e && m_cnt < MAXC) m_cnt++;
        if (idle && r) m_ip = 1;
        else if (m_ip && claim_i) begin m_ip = 0; m_busy = 1; end
        else if (m_busy && complete_i) m_busy = 0;
        m_prev = src_i;
    endfunction

    task automatic step(input int s, input int c, input int p);
        src_i = (s != 0); claim_i = (c != 0); complete_i = (p != 0);
        @(posedge clk);
        if (rst_ni) model_step(); else model_reset();
        @(negedge clk);
        if (rst_ni) begin
            chk("model_ip", CW'(ip_o), int'(m_ip));
            chk("model_cnt", cnt_o, m_cnt);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) step(0, 0, 0);
        chk("reset_ip", CW'(ip_o), 0);
        chk("reset_cnt", cnt_o, 0);
        rst_ni = 1'b1;

        // Level mode: src held, claim at cycle 5, complete at cycle 10.
        for (int c = 1; c <= 11; c++) begin
            step(1, int'(c == 5), int'(c == 10));
            chk("level_ip", CW'(ip_o), (c >= 5 && c <= 10) ? 0 : 1);
        end
        step(0, 1, 0); step(0, 0, 1); step(0, 0, 0);
        chk("level_idle_ip", CW'(ip_o), 0);
        step(0, 1, 0);
        chk("level_spurious_claim_ip", CW'(ip_o), 0);

        // Edge mode: three pulses while CLAIMED.
        edge_lvl_i = 1'b1;
        step(1, 0, 0);
        chk("edge_first_ip", CW'(ip_o), 1);
        step(0, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            step(1, 0, 0);
            chk("edge_cnt_step", cnt_o, sat(k));
            step(0, 0, 0);
        end
        step(0, 0, 1);
        chk("complete_ip", CW'(ip_o), 0);
        step(0, 0, 0);
        chk("rearm_ip", CW'(ip_o), 1);
        chk("rearm_cnt", cnt_o, sat(3) - 1);
        repeat (MAXC + 1) begin step(0, 1, 0); step(0, 0, 1); step(0, 0, 0); end
        chk("drain_cnt", cnt_o, 0);
        chk("drain_ip", CW'(ip_o), 0);

        // Saturation: 12 edges while CLAIMED.
        step(1, 0, 0); step(0, 1, 0);
        repeat (12) begin step(1, 0, 0); step(0, 0, 0); end
        chk("sat_cnt", cnt_o, MAXC);
        step(0, 0, 1);
        chk("sat_idle_ip", CW'(ip_o), 0);
        repeat (MAXC + 1) begin step(0, 0, 0); step(0, 1, 0); step(0, 0, 1); end
        chk("sat_drain_cnt", cnt_o, 0);

        // Claim and complete together in PENDING: claim wins, stays CLAIMED.
        step(1, 0, 0);
        chk("sim_pending_ip", CW'(ip_o), 1);
        step(0, 1, 1);
        chk("claim_complete_ip", CW'(ip_o), 0);
        step(1, 0, 0);
        chk("still_claimed_ip", CW'(ip_o), 0);
        chk("still_claimed_cnt", cnt_o, sat(1));
        step(0, 0, 0); step(1, 0, 0); step(0, 0, 1);
        // Edge in IDLE with stored edges: forwarded, count unchanged.
        step(1, 0, 0);
        chk("edge_dec_ip", CW'(ip_o), 1);
        chk("edge_dec_cnt", cnt_o, sat(2));
        step(0, 0, 1);
        chk("spurious_complete_ip", CW'(ip_o), 1);
        chk("spurious_complete_cnt", cnt_o, sat(2));
        repeat (MAXC + 1) begin step(0, 1, 0); step(0, 0, 1); step(0, 0, 0); end
        step(0, 1, 0);
        chk("spurious_claim_ip", CW'(ip_o), 0);
        chk("spurious_claim_cnt", cnt_o, 0);

        // Asynchronous reset mid-CLAIMED with stored edges.
        step(1, 0, 0); step(0, 1, 0);
        repeat (4) begin step(1, 0, 0); step(0, 0, 0); end
        chk("pre_reset_cnt", cnt_o, sat(4));
        #2 rst_ni = 1'b0;
        #1 model_reset();
        chk("async_reset_ip", CW'(ip_o), 0);
        chk("async_reset_cnt", cnt_o, 0);
        step(0, 0, 0); step(0, 0, 0);
        rst_ni = 1'b1;
        step(1, 0, 0);
        chk("post_reset_ip", CW'(ip_o), 1);
        chk("post_reset_cnt", cnt_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/plic_gateway.md
# plic_gateway

Per-source interrupt gateway of the PLIC. It converts one raw interrupt line, either level- or edge-triggered, into the pending bit consumed by the per-target priority/threshold logic. It also closes the loop on the claim/complete protocol: a claim takes the request out of pending, and a complete re-arms the source. One instance is placed per interrupt source, between the source pin and the pending/priority arbitration.

## Interface
- MAX_PENDING_COUNT, 8, maximum number of un-serviced rising edges remembered in edge mode (≥1).
- CNT_BITS, $clog2(MAX_PENDING_COUNT+1), width of the edge counter (derived; do not override).
- rst_ni  input  1  asynchronous, active-low reset.
- clk_i  input  1  system clock, rising edge.
- src_i  input  1  raw interrupt request, already synchronous to clk_i.
- edge_lvl_i  input  1  trigger mode: 1 = rising-edge, 0 = level (active high).
- claim_i  input  1  single-cycle pulse: a target claimed this source's ID.
- complete_i  input  1  single-cycle pulse: a target wrote completion for this source's ID.
- ip_o  output  1  interrupt pending, to priority/target logic.
- cnt_o  output  CNT_BITS  number of stored edges not yet forwarded (debug/status).

## Operation
- FSM states, held in a state register:
  - IDLE: gateway ready to forward a request.
  - PENDING: ip_o = 1.
  - CLAIMED: the handler is running and ip_o = 0.
- ip_o is a registered decode of state == PENDING. It has no combinational path from any input.
- Edge detector: src_q stores src_i from the previous cycle. edge = src_i & ~src_q. src_q resets to 0.
- Transition IDLE → PENDING: taken when req is true.
  - Level mode: req = src_i.
  - Edge mode: req = edge | (cnt ≠ 0).
- Transition PENDING → CLAIMED: on claim_i.
  - A level source that deasserts while PENDING stays PENDING until it is claimed.
- Transition CLAIMED → IDLE: on complete_i.
  - If req is also true in that cycle, the FSM still goes to IDLE. PENDING is reached on the following edge, so ip_o always shows at least one low cycle between requests.
- Counter rules in edge mode. inc = edge and the edge is not consumed this cycle by IDLE → PENDING. dec = IDLE → PENDING taken with cnt ≠ 0 and no edge this cycle.
  - inc & ~dec: cnt + 1, saturating at MAX_PENDING_COUNT. Further edges are dropped.
  - dec & ~inc: cnt − 1.
  - inc & dec, or neither: cnt holds.
- Counter in level mode: cnt is cleared to 0 every cycle.
- Ignored inputs:
  - claim_i outside PENDING is ignored.
  - complete_i outside CLAIMED is ignored.
  - If claim_i and complete_i arrive together in PENDING, only the claim acts.
- Mode changes: edge_lvl_i is allowed to change only while IDLE with cnt = 0. Behaviour after a mode change in any other state is that the FSM continues from its current state and applies the new mode's req rule.

## Timing
- Reset values: state = IDLE, ip_o = 0, cnt_o = 0, src_q = 0.
- Reset mid-operation drops all pending edges and any claim in progress.
- Latency from src_i (level high, or rising edge) sampled at clock edge k while IDLE: ip_o = 1 from edge k.
- Latency from claim_i at edge k: ip_o = 0 from edge k.
- Latency from complete_i at edge k: IDLE from edge k. With req already true, ip_o = 1 again from edge k+1.
- cnt_o is registered and updates on the same edge as the event that changes it.
- Each source has exactly one claim/complete cycle outstanding at a time.

## Configuration
- PLIC_GATEWAY_EDGE_COUNT_EN defined: the edge counter is implemented as described above, saturating at MAX_PENDING_COUNT.
- PLIC_GATEWAY_EDGE_COUNT_EN undefined:
  - The counter becomes a 1-bit sticky flag, equivalent to MAX_PENDING_COUNT = 1.
  - Edges arriving while PENDING or CLAIMED collapse into one stored request.
  - cnt_o bit 0 carries the flag and the upper bits are tied to 0.

## Structure
- plic_pkg holds:
  - typedef enum logic [1:0] gw_state_t {GW_IDLE, GW_PENDING, GW_CLAIMED}.
  - A constant GW_MODE_LEVEL = 1'b0 and a constant GW_MODE_EDGE = 1'b1.
- One sub-module, plic_gateway_edge_cnt. It contains the edge detector plus the saturating up/down counter, with inputs src, inc-enable, dec and outputs edge, cnt. The macro selects the counter width inside this sub-module.

## Test plan
- Level mode: src_i = 1 held, then claim_i at cycle 5 and complete_i at cycle 10. Required response:
  - ip_o = 1 during cycles 1–4 and 0 during cycles 5–10.
  - ip_o = 1 again at cycle 11.
- Edge mode, 3 pulses on src_i while CLAIMED. Required response:
  - cnt_o steps 1, 2, 3.
  - After complete_i: ip_o = 1 the next cycle and cnt_o = 2.
  - Repeated claim/complete drains cnt_o to 0.
- Saturation with MAX_PENDING_COUNT = 8 and the macro defined: 12 edges while CLAIMED leave cnt_o = 8. With the macro undefined, the same stimulus leaves cnt_o = 1.
- Simultaneous events:
  - claim_i and complete_i together in PENDING give state CLAIMED with ip_o = 0.
  - An edge coinciding with a counter decrement in IDLE leaves cnt_o unchanged.
- Spurious inputs: complete_i while PENDING and claim_i while IDLE cause no state change, and ip_o and cnt_o are unchanged.
- Reset: rst_ni asserted mid-CLAIMED with cnt_o = 4 gives ip_o = 0 and cnt_o = 0 immediately (asynchronously). After release, a new edge sets ip_o = 1 next cycle.
